proc_clock_ctrl: RTL

Parametrised clock-enable and execution controller that sits between the board clock and the single-cycle processor, replacing fixed divide-by-2/divide-by-4 clock derivation with a single-clock enable scheme. It generates per-block enables for imem, dmem, regfile and processor at a configurable divide ratio. It adds run/halt/single-step control, an optional PC breakpoint and a retired-cycle counter for bring-up and debug.

---
 rtl/proc_clock_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/proc_clock_ctrl.sv
// Single-clock enable generator and run/halt/step controller for the single-cycle processor.
// Define CLKCTRL_BREAKPOINT_EN to build the PC breakpoint, its mask flag and the BREAK state.
module proc_clock_ctrl #(
   parameter int DIV   = 4,
   parameter int PC_W  = 12,
   parameter int CNT_W = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    run_req,
   input  logic                    halt_req,
   input  logic                    step_req,
   input  logic                    bp_en,
   input  logic [PC_W-1:0]         bp_addr,
   input  logic [PC_W-1:0]         pc,
   output logic                    imem_en,
   output logic                    dmem_en,
   output logic                    processor_en,
   output logic                    regfile_en,
   output logic [$clog2(DIV)-1:0]  phase,
   output logic [1:0]              state,
   output logic                    halted,
   output logic [CNT_W-1:0]        cycle_count
);

   localparam int PH_W = $clog2(DIV);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);

   typedef enum logic [1:0] {
      S_HALT  = 2'd0,
      S_RUN   = 2'd1,
      S_STEP  = 2'd2,
      S_BREAK = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              pend_q, pend_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              active;
   logic              commit;
   logic              bp_hit;

`ifdef CLKCTRL_BREAKPOINT_EN
   logic              mask_q, mask_d;

   // Breakpoints are only checked at the start of a processor cycle so a hit never issues a commit.
   assign bp_hit = bp_en && (pc == bp_addr) && !mask_q && (phase_q == '0);
`else
   logic              unused_bp;

   assign bp_hit    = 1'b0;
   assign unused_bp = ^{bp_en, bp_addr, pc};
`endif

   assign active = (state_q == S_RUN) || (state_q == S_STEP);
   assign commit = active && (phase_q == PH_LAST);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      pend_d  = pend_q;
      count_d = commit ? count_q + CNT_W'(1) : count_q;
`ifdef CLKCTRL_BREAKPOINT_EN
      mask_d  = commit ? 1'b0 : mask_q;
`endif
      case (state_q)
         S_HALT: begin
            if (halt_req) begin
               state_d = S_HALT;
            end else if (step_req) begin
               state_d = S_STEP;
            end else if (run_req) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (bp_hit) begin
               state_d = S_BREAK;
               pend_d  = 1'b0;
            end else begin
               phase_d = commit ? '0 : phase_q + PH_W'(1);
               if (commit) begin
                  if (pend_q || halt_req) begin
                     state_d = S_HALT;
                     pend_d  = 1'b0;
                  end
               end else if (halt_req) begin
                  pend_d = 1'b1;
               end
            end
         end
         S_STEP: begin
            phase_d = commit ? '0 : phase_q + PH_W'(1);
            if (commit) begin
               state_d = S_HALT;
            end
         end
         default: begin
`ifdef CLKCTRL_BREAKPOINT_EN
            // Leaving BREAK masks the breakpoint for one cycle so the matching PC can execute.
            if (halt_req) begin
               state_d = S_HALT;
               mask_d  = 1'b0;
            end else if (step_req) begin
               state_d = S_STEP;
               mask_d  = 1'b1;
            end else if (run_req) begin
               state_d = S_RUN;
               mask_d  = 1'b1;
            end
`else
            state_d = S_HALT;
            phase_d = '0;
`endif
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_HALT;
         phase_q <= '0;
         pend_q  <= 1'b0;
         count_q <= '0;
`ifdef CLKCTRL_BREAKPOINT_EN
         mask_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
         count_q <= count_d;
`ifdef CLKCTRL_BREAKPOINT_EN
         mask_q  <= mask_d;
`endif
      end
   end

   assign imem_en      = active;
   assign dmem_en      = active;
   assign processor_en = commit;
   assign regfile_en   = commit;
   assign phase        = phase_q;
   assign state        = state_q;
   assign halted       = (state_q == S_HALT) || (state_q == S_BREAK);
   assign cycle_count  = count_q;

endmodule
